// File: rtl/mips_rf_pkg.sv
// Shared defaults and typedefs for the MIPS register file with busy scoreboard.
package mips_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, write port, issue port, busy status.
interface mips_regfile_sb_if
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] readRegister1;
    logic [ADDR_W-1:0] readRegister2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              busy1;
    logic              busy2;
    logic              we;
    logic [ADDR_W-1:0] writeRegister;
    logic [DATA_W-1:0] writeData;
    logic              issueValid;
    logic [ADDR_W-1:0] issueRegister;
    logic [ADDR_W:0]   pendingCount;

    modport master (
        output readRegister1, readRegister2, we, writeRegister, writeData,
               issueValid, issueRegister,
        input  readData1, readData2, busy1, busy2, pendingCount
    );

    modport slave (
        input  readRegister1, readRegister2, we, writeRegister, writeData,
               issueValid, issueRegister,
        output readData1, readData2, busy1, busy2, pendingCount
    );

endinterface

// File: rtl/mips_rf_scoreboard.sv
// Per-register busy bits for multi-cycle producers, plus a running count of busy registers.
module mips_rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   setEn,
    input  logic [ADDR_W-1:0]      setRegister,
    input  logic                   clrEn,
    input  logic [ADDR_W-1:0]      clrRegister,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        pendingCount
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0] busyNext;
    logic [ADDR_W:0]  countNext;
    logic             setsNew;
    logic             clearsOld;

    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        busyNext = busy;
        // Set is applied after clear: a newer producer owns the register over a retiring one.
        if (clrEn) busyNext[clrRegister] = 1'b0;
        if (setEn) busyNext[setRegister] = 1'b1;

        setsNew   = setEn && !busy[setRegister];
        clearsOld = clrEn && busy[clrRegister] && !(setEn && setRegister == clrRegister);

        countNext = pendingCount;
        if (setsNew && !clearsOld) begin
            countNext = pendingCount + 1'b1;
        end else if (clearsOld && !setsNew) begin
            countNext = pendingCount - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            pendingCount <= '0;
        end else begin
            busy         <= busyNext;
            pendingCount <= countNext;
        end
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file: two bypassed combinational read ports, one write port,
// optional hardwired zero register and a busy scoreboard for stall logic.
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mips_regfile_sb_if.slave   bus
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busyVec;
    logic              writeEn;
    logic              issueEn;
    logic              hit1;
    logic              hit2;
    logic              mask1;
    logic              mask2;

    assign writeEn = bus.we && !(ZERO_REG && bus.writeRegister == '0);
    assign issueEn = bus.issueValid && !(ZERO_REG && bus.issueRegister == '0);

    // NOTE: the array is cleared on reset because software may read a register before writing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[bus.writeRegister] <= bus.writeData;
        end
    end

    mips_rf_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .setEn       (issueEn),
        .setRegister (bus.issueRegister),
        .clrEn       (writeEn),
        .clrRegister (bus.writeRegister),
        .busy        (busyVec),
        .pendingCount(bus.pendingCount)
    );

    // A same-cycle writeback both forwards its data and resolves the hazard.
    assign hit1  = bus.we && bus.writeRegister == bus.readRegister1;
    assign hit2  = bus.we && bus.writeRegister == bus.readRegister2;
    assign mask1 = rst || (ZERO_REG && bus.readRegister1 == '0);
    assign mask2 = rst || (ZERO_REG && bus.readRegister2 == '0);

    always_comb begin
        bus.readData1 = regs[bus.readRegister1];
        bus.busy1     = busyVec[bus.readRegister1];
        if (hit1) begin
            bus.readData1 = bus.writeData;
            bus.busy1     = 1'b0;
        end
        if (mask1) begin
            bus.readData1 = '0;
            bus.busy1     = 1'b0;
        end
    end

    always_comb begin
        bus.readData2 = regs[bus.readRegister2];
        bus.busy2     = busyVec[bus.readRegister2];
        if (hit2) begin
            bus.readData2 = bus.writeData;
            bus.busy2     = 1'b0;
        end
        if (mask2) begin
            bus.readData2 = '0;
            bus.busy2     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed plus randomized bench for mips_regfile_sb, run on a ZERO_REG=1 and a ZERO_REG=0 instance.
module tb_mips_regfile_sb;
    import mips_rf_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    reg_addr_t rr1, rr2, wr, ir;
    logic      we, iv;
    reg_data_t wd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) busA ();
    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) busB ();

    assign busA.readRegister1 = rr1;
    assign busA.readRegister2 = rr2;
    assign busA.we            = we;
    assign busA.writeRegister = wr;
    assign busA.writeData     = wd;
    assign busA.issueValid    = iv;
    assign busA.issueRegister = ir;
    assign busB.readRegister1 = rr1;
    assign busB.readRegister2 = rr2;
    assign busB.we            = we;
    assign busB.writeRegister = wr;
    assign busB.writeData     = wd;
    assign busB.issueValid    = iv;
    assign busB.issueRegister = ir;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dutA (
        .clk(clk), .rst(rst), .bus(busA)
    );
    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dutB (
        .clk(clk), .rst(rst), .bus(busB)
    );

    // Reference model: index 0 mirrors ZERO_REG=1, index 1 mirrors ZERO_REG=0.
    logic [31:0] mReg  [2][32];
    bit          mBusy [2][32];
    bit          zr    [2] = '{1'b1, 1'b0};

    function automatic logic [31:0] mRead(int k, int a);
        if (rst) return 32'h0;
        if (zr[k] && a == 0) return 32'h0;
        if (we && int'(wr) == a) return wd;
        return mReg[k][a];
    endfunction

    function automatic bit mBusyRd(int k, int a);
        if (rst) return 1'b0;
        if (zr[k] && a == 0) return 1'b0;
        return mBusy[k][a] && !(we && int'(wr) == a);
    endfunction

    function automatic int mCount(int k);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mBusy[k][i]);
        return n;
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    mReg[k][i]  = 32'h0;
                    mBusy[k][i] = 1'b0;
                end
            end else begin
                if (we && !(zr[k] && wr == 0)) begin
                    mReg[k][wr]  = wd;
                    mBusy[k][wr] = 1'b0;
                end
                if (iv && !(zr[k] && ir == 0)) mBusy[k][ir] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOne(input int k, input string nm, input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2, input logic [5:0] cnt);
        chk({nm, ".readData1"},    64'(d1),  64'(mRead(k, int'(rr1))));
        chk({nm, ".readData2"},    64'(d2),  64'(mRead(k, int'(rr2))));
        chk({nm, ".busy1"},        64'(b1),  64'(mBusyRd(k, int'(rr1))));
        chk({nm, ".busy2"},        64'(b2),  64'(mBusyRd(k, int'(rr2))));
        chk({nm, ".pendingCount"}, 64'(cnt), 64'(mCount(k)));
    endtask

    task automatic drive(input logic r, input reg_addr_t a1, input reg_addr_t a2, input logic w,
                         input reg_addr_t wa, input reg_data_t wdat, input logic i, input reg_addr_t ia);
        rst = r; rr1 = a1; rr2 = a2; we = w; wr = wa; wd = wdat; iv = i; ir = ia;
        #1;
        checkOne(0, "zr1", busA.readData1, busA.readData2, busA.busy1, busA.busy2, busA.pendingCount);
        checkOne(1, "zr0", busB.readData1, busB.readData2, busB.busy1, busB.busy2, busB.pendingCount);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #2;
    endtask

    function automatic reg_addr_t pick();
        if ($urandom_range(0, 1) == 1) return reg_addr_t'($urandom_range(0, 7));
        return reg_addr_t'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1; rr1 = '0; rr2 = '0; we = 1'b0; wr = '0; wd = '0; iv = 1'b0; ir = '0;
        @(posedge clk);
        modelEdge();
        #2;
        drive(1'b1, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();

        // Reset discards a concurrent write and issue.
        drive(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("preload_r5", 64'(busA.readData1), 64'h1234);
        tick();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5);
        chk("rst_read_zero", 64'(busA.readData1), 64'h0);
        tick();
        drive(1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("post_rst_r5", 64'(busA.readData1), 64'h0);
        chk("post_rst_busy", 64'(busA.busy1), 64'h0);
        chk("post_rst_count", 64'(busA.pendingCount), 64'h0);
        tick();

        // Same-cycle bypass, then array read.
        drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
        chk("bypass_p1", 64'(busA.readData1), 64'hDEADBEEF);
        chk("bypass_p2", 64'(busA.readData2), 64'hDEADBEEF);
        tick();
        drive(1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("array_p1", 64'(busA.readData1), 64'hDEADBEEF);
        tick();

        // Zero register: write and issue r0.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("zr1_r0_data", 64'(busA.readData1), 64'h0);
        chk("zr1_r0_busy", 64'(busA.busy1), 64'h0);
        chk("zr1_r0_count", 64'(busA.pendingCount), 64'h0);
        chk("zr0_r0_data", 64'(busB.readData1), 64'hFFFFFFFF);
        chk("zr0_r0_busy", 64'(busB.busy1), 64'h1);
        chk("zr0_r0_count", 64'(busB.pendingCount), 64'h1);
        tick();
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();

        // Scoreboard issue / writeback on r3.
        drive(1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        tick();
        drive(1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("issue_busy1", 64'(busA.busy1), 64'h1);
        chk("issue_count", 64'(busA.pendingCount), 64'h1);
        tick();
        drive(1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
        chk("wb_busy1_same_cycle", 64'(busA.busy1), 64'h0);
        tick();
        drive(1'b0, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("wb_count", 64'(busA.pendingCount), 64'h0);
        tick();

        // Collision on busy r9: set wins, data still written; re-issue does not count.
        drive(1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        tick();
        drive(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9);
        tick();
        drive(1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        chk("coll_busy", 64'(busA.busy1), 64'h1);
        chk("coll_data", 64'(busA.readData1), 64'h55);
        chk("coll_count", 64'(busA.pendingCount), 64'h1);
        tick();
        drive(1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("reissue_count", 64'(busA.pendingCount), 64'h1);
        tick();
        drive(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h66, 1'b0, 5'd0);
        tick();

        // Fill every register, then drain.
        for (int a = 1; a < 32; a++) begin
            drive(1'b0, reg_addr_t'(a), 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, reg_addr_t'(a));
            tick();
        end
        drive(1'b0, 5'd31, 5'd1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        chk("fill_count_zr1", 64'(busA.pendingCount), 64'd31);
        chk("fill_count_zr0", 64'(busB.pendingCount), 64'd31);
        tick();
        drive(1'b0, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("full_count_zr1", 64'(busA.pendingCount), 64'd31);
        chk("full_count_zr0", 64'(busB.pendingCount), 64'd32);
        tick();
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, reg_addr_t'(a), reg_addr_t'(31 - a), 1'b1, reg_addr_t'(a), 32'(a * 3), 1'b0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd2, 5'd30, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("drain_count_zr1", 64'(busA.pendingCount), 64'd0);
        chk("drain_count_zr0", 64'(busB.pendingCount), 64'd0);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            drive(logic'($urandom_range(0, 39) == 0), pick(), pick(), logic'($urandom_range(0, 1)),
                  pick(), reg_data_t'($urandom), logic'($urandom_range(0, 1)), pick());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_regfile_sb.md
# mips_regfile_sb

Parametrised MIPS general-purpose register file with two combinational read ports, one write port, write-to-read bypass, a hardwired zero register and a per-register busy scoreboard for multi-cycle producers such as loads and mult/div. It sits between decode (reads, issue marking) and writeback (writes, busy clearing) in the MIPS datapath, and replaces the fixed 32x32 register file. Stall logic uses its busy flags and outstanding count.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, and writes to it are dropped; 0 = register 0 is an ordinary register

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- readRegister1  in  ADDR_W  read port 1 address
- readRegister2  in  ADDR_W  read port 2 address
- readData1  out  DATA_W  read port 1 data (combinational)
- readData2  out  DATA_W  read port 2 data (combinational)
- busy1  out  1  readRegister1 has an outstanding producer
- busy2  out  1  readRegister2 has an outstanding producer
- we  in  1  write enable
- writeRegister  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- issueValid  in  1  decode issues a multi-cycle producer
- issueRegister  in  ADDR_W  destination of the issued producer
- pendingCount  out  ADDR_W+1  number of busy registers

## Operation
- Storage: NREGS x DATA_W array plus NREGS busy bits.
- Write: on a rising edge with we=1 and rst=0, array[writeRegister] <= writeData. The write is dropped when ZERO_REG=1 and writeRegister=0.
- A write also clears busy[writeRegister].
- Read, per port n:
  - Forced to 0 when rst=1, or when ZERO_REG=1 and readRegisterN=0.
  - Otherwise, when we=1 and writeRegister=readRegisterN, the port returns writeData (bypass).
  - Otherwise the port returns array[readRegisterN].
- busyN = busy[readRegisterN] AND NOT (we=1 AND writeRegister=readRegisterN). This means a writeback resolves a hazard in the same cycle. busyN is forced to 0 under rst, and for register 0 when ZERO_REG=1.
- Issue: on a rising edge with issueValid=1 and rst=0, busy[issueRegister] <= 1. Issue to register 0 is ignored when ZERO_REG=1.
- Simultaneous issue and write to the same register: set wins, because the newer producer owns the register. The data write still occurs.
- Issue to a register that is already busy: no change, and pendingCount is not incremented.
- pendingCount: up/down counter tracking the popcount of busy bits.
  - +1 when an issue sets a clear bit.
  - -1 when a write clears a set bit.
  - Net 0 when both happen in the same cycle. It never exceeds NREGS.
- Two read ports at the same address return identical data and busy.

## Timing
- Reset: rst sampled at rising edge. Next cycle: all array entries 0, all busy bits 0, pendingCount 0. While rst=1, readData1/2=0 and busy1/2=0.
- rst asserted mid-operation: any concurrent we or issueValid in that cycle is discarded.
- Read latency 0: combinational from readRegisterN and the bypass inputs.
- Write latency: visible at the same-cycle read via bypass, and from the array on the next cycle.
- Issue latency: busy visible one cycle after the issue edge.
- No reads on the falling edge; no other clock edges used.

## Structure
- Package mips_rf_pkg: default DATA_W/ADDR_W constants and typedefs reg_addr_t and reg_data_t.
- Sub-module mips_rf_scoreboard holds the busy bits, the set/clear priority and pendingCount.
- Top level holds the array, bypass muxes and zero-register masking.

## Test plan
- Reset: preload r5=0x1234 then assert rst for 1 cycle -> readData1(r5)=0, busy all 0, pendingCount=0. A same-cycle we to r5 is discarded.
- Bypass: we=1, writeRegister=7, writeData=0xDEADBEEF, readRegister1=readRegister2=7 in the same cycle -> both ports read 0xDEADBEEF that cycle. Next cycle with we=0 -> still 0xDEADBEEF.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to r0 and issue r0 -> readData=0, busy=0, pendingCount=0. With ZERO_REG=0 the same writes read back 0xFFFFFFFF.
- Scoreboard:
  - Issue r3 -> next cycle busy1=1 (readRegister1=3), pendingCount=1.
  - Writeback r3 -> busy1=0 in that same cycle, pendingCount=0 the next cycle.
- Collision: r9 busy. Same cycle issue r9 and we r9=0x55 -> r9 stays busy, reads 0x55, pendingCount unchanged. Re-issue of busy r9 -> count unchanged.
- Fill: issue all 31 nonzero registers (ZERO_REG=1) -> pendingCount=31. Writeback all -> pendingCount=0, no wrap.
